// File: rtl/dmem_arbiter_if.sv
// Requester-side bus for one port of the data-memory arbiter.
// master = requester, slave = arbiter.
interface dmem_arbiter_if;
   logic        req;
   logic        we;
   logic        lock;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        gnt;
   logic        rvalid;
   logic [31:0] rdata;

   modport master (output req, output we, output lock, output addr, output wdata,
                   input gnt, input rvalid, input rdata);
   modport slave  (input req, input we, input lock, input addr, input wdata,
                   output gnt, output rvalid, output rdata);
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port data memory: fixed-priority with a
// starvation guard or round-robin, locked bursts, and registered read return.
module dmem_arbiter #(
   parameter int unsigned PRIO     = 0,
   parameter int unsigned MAX_WAIT = 8
) (
   input  logic           clk,
   input  logic           reset,
   dmem_arbiter_if.slave  p0,
   dmem_arbiter_if.slave  p1,
   output logic           mem_read,
   output logic           mem_write,
   output logic [31:0]    mem_addr,
   output logic [31:0]    mem_wd,
   input  logic [31:0]    mem_rd
);

   typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

   state_e      state_q;
   logic [7:0]  wait_q;
   logic        rr_last_q;
   logic        rvalid0_q, rvalid1_q;
   logic [31:0] rdata0_q, rdata1_q;
   logic        gnt0, gnt1;
   logic        starved;

   assign starved   = (wait_q == 8'(MAX_WAIT));
   assign p0.gnt    = gnt0;
   assign p1.gnt    = gnt1;
   assign p0.rvalid = rvalid0_q;
   assign p1.rvalid = rvalid1_q;
   assign p0.rdata  = rdata0_q;
   assign p1.rdata  = rdata1_q;

   // Grants are combinational and suppressed while reset is high.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!reset) begin
         unique case (state_q)
            StIdle: begin
               if (p0.req && p1.req) begin
                  if (PRIO == 0) begin
                     gnt1 = starved;
                     gnt0 = !starved;
                  end else begin
                     gnt1 = !rr_last_q;
                     gnt0 = rr_last_q;
                  end
               end else begin
                  gnt0 = p0.req;
                  gnt1 = p1.req;
               end
            end
            StOwn0:  gnt0 = p0.req;
            StOwn1:  gnt1 = p1.req;
            default: ;
         endcase
      end
   end

   always_comb begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
      mem_addr  = 32'h0;
      mem_wd    = 32'h0;
      if (gnt0) begin
         mem_read  = !p0.we;
         mem_write = p0.we;
         mem_addr  = p0.addr;
         mem_wd    = p0.wdata;
      end else if (gnt1) begin
         mem_read  = !p1.we;
         mem_write = p1.we;
         mem_addr  = p1.addr;
         mem_wd    = p1.wdata;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= StIdle;
         wait_q    <= 8'd0;
         rr_last_q <= 1'b1;
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
         rdata0_q  <= 32'h0;
         rdata1_q  <= 32'h0;
      end else begin
         rvalid0_q <= gnt0 && !p0.we;
         rvalid1_q <= gnt1 && !p1.we;
         if (gnt0 && !p0.we) rdata0_q <= mem_rd;
         if (gnt1 && !p1.we) rdata1_q <= mem_rd;

         if (gnt0)      rr_last_q <= 1'b0;
         else if (gnt1) rr_last_q <= 1'b1;

         if (!p1.req || gnt1) wait_q <= 8'd0;
         else if (!starved)   wait_q <= wait_q + 8'd1;

         unique case (state_q)
            StIdle: begin
               if (gnt0 && p0.lock)      state_q <= StOwn0;
               else if (gnt1 && p1.lock) state_q <= StOwn1;
            end
            // A starved port 1 breaks a port-0 burst at its next beat.
            StOwn0: if (!p0.req || !p0.lock || starved) state_q <= StIdle;
            StOwn1: if (!p1.req || !p1.lock) state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench: fixed-priority instance plus a round-robin instance, each with
// a small behavioural DataMemory.
module tb_dmem_arbiter;
   logic clk;
   logic reset;
   int   n_chk;
   int   n_pass;

   dmem_arbiter_if a0 ();
   dmem_arbiter_if a1 ();
   dmem_arbiter_if b0 ();
   dmem_arbiter_if b1 ();

   logic        rd_en_a, wr_a, rd_en_b, wr_b;
   logic [31:0] addr_a, wd_a, rd_a, addr_b, wd_b, rd_b;
   logic [31:0] mem_a [0:63];
   logic [31:0] mem_b [0:63];

   dmem_arbiter #(.PRIO(0), .MAX_WAIT(8)) u_fp (
      .clk(clk), .reset(reset), .p0(a0), .p1(a1),
      .mem_read(rd_en_a), .mem_write(wr_a), .mem_addr(addr_a), .mem_wd(wd_a), .mem_rd(rd_a)
   );

   dmem_arbiter #(.PRIO(1), .MAX_WAIT(8)) u_rr (
      .clk(clk), .reset(reset), .p0(b0), .p1(b1),
      .mem_read(rd_en_b), .mem_write(wr_b), .mem_addr(addr_b), .mem_wd(wd_b), .mem_rd(rd_b)
   );

   assign rd_a = mem_a[addr_a[7:2]];
   assign rd_b = mem_b[addr_b[7:2]];
   always @(posedge clk) if (wr_a) mem_a[addr_a[7:2]] <= wd_a;
   always @(posedge clk) if (wr_b) mem_b[addr_b[7:2]] <= wd_b;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      else n_pass++;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_all;
      a0.req = 0; a0.we = 0; a0.lock = 0; a0.addr = 0; a0.wdata = 0;
      a1.req = 0; a1.we = 0; a1.lock = 0; a1.addr = 0; a1.wdata = 0;
      b0.req = 0; b0.we = 0; b0.lock = 0; b0.addr = 0; b0.wdata = 0;
      b1.req = 0; b1.we = 0; b1.lock = 0; b1.addr = 0; b1.wdata = 0;
   endtask

   initial begin
      n_chk = 0;
      n_pass = 0;
      reset = 1'b1;
      idle_all();
      a0.req = 1; a0.we = 1; a0.addr = 32'h40; a0.wdata = 32'hFFFF_FFFF;
      #2;
      check("rst_gnt0", a0.gnt, 0);
      check("rst_mwr", wr_a, 0);
      check("rst_maddr", addr_a, 0);
      check("rst_rv0", a0.rvalid, 0);
      check("rst_rd0", a0.rdata, 0);
      tick(); tick();
      reset = 1'b0;
      idle_all();
      tick();

      // Write from p1, then read it back through p0.
      a1.req = 1; a1.we = 1; a1.addr = 32'h20; a1.wdata = 32'hA5A5_A5A5;
      #1;
      check("t1_gnt1", a1.gnt, 1);
      check("t1_mwr", wr_a, 1);
      check("t1_maddr", addr_a, 32'h20);
      tick();
      a1.req = 0; a1.we = 0;
      a0.req = 1; a0.we = 0; a0.addr = 32'h20;
      #1;
      check("t1_gnt0", a0.gnt, 1);
      check("t1_mrd", rd_en_a, 1);
      check("t1_rv0_early", a0.rvalid, 0);
      check("t1_rv1_wr", a1.rvalid, 0);
      tick();
      a0.req = 0;
      #1;
      check("t1_rv0", a0.rvalid, 1);
      check("t1_rdata0", a0.rdata, 32'hA5A5_A5A5);
      tick();
      #1;
      check("t1_rv0_off", a0.rvalid, 0);
      check("t1_rdata0_hold", a0.rdata, 32'hA5A5_A5A5);
      tick();

      // Starvation guard: p1 forced in on cycle 8.
      a0.req = 1; a0.addr = 32'h20;
      a1.req = 1; a1.addr = 32'h24;
      for (int c = 0; c <= 9; c++) begin
         #1;
         check($sformatf("t2_gnt0_c%0d", c), a0.gnt, (c != 8) ? 1 : 0);
         check($sformatf("t2_gnt1_c%0d", c), a1.gnt, (c == 8) ? 1 : 0);
         if (c == 9) check("t2_rv1", a1.rvalid, 1);
         tick();
      end
      idle_all();
      tick(); tick();

      // Locked 3-beat p0 burst blocks p1 until the burst ends.
      a0.req = 1; a0.lock = 1; a0.addr = 32'h20;
      a1.req = 1; a1.addr = 32'h24;
      for (int c = 0; c < 3; c++) begin
         a0.lock = (c < 2);
         #1;
         check($sformatf("t4_gnt0_c%0d", c), a0.gnt, 1);
         check($sformatf("t4_gnt1_c%0d", c), a1.gnt, 0);
         tick();
      end
      a0.req = 0; a0.lock = 0;
      #1;
      check("t4_gnt1_after", a1.gnt, 1);
      tick();
      idle_all();
      tick(); tick();

      // Lock break: endless p0 lock, starved p1 wins on cycle 9.
      a0.req = 1; a0.lock = 1; a0.addr = 32'h20;
      a1.req = 1; a1.addr = 32'h24;
      for (int c = 0; c <= 9; c++) begin
         #1;
         check($sformatf("lb_gnt1_c%0d", c), a1.gnt, (c == 9) ? 1 : 0);
         tick();
      end
      idle_all();
      tick(); tick();

      // p0 drops req inside OWN0.
      a0.req = 1; a0.lock = 1; a0.addr = 32'h20;
      tick();
      a0.req = 0; a0.lock = 0;
      a1.req = 1; a1.addr = 32'h24;
      #1;
      check("t6_gnt1_own0", a1.gnt, 0);
      check("t6_rv0_prev", a0.rvalid, 1);
      tick();
      #1;
      check("t6_gnt1", a1.gnt, 1);
      check("t6_rv0_drop", a0.rvalid, 0);
      tick();
      idle_all();
      tick();

      // Reset in the middle of an OWN0 write.
      a1.req = 1; a1.we = 1; a1.addr = 32'h40; a1.wdata = 32'h1122_3344;
      tick();
      a1.req = 0; a1.we = 0;
      a0.req = 1; a0.lock = 1; a0.addr = 32'h40;
      tick();
      a0.we = 1; a0.wdata = 32'hDEAD_BEEF;
      reset = 1'b1;
      #1;
      check("t5_mwr", wr_a, 0);
      check("t5_gnt0", a0.gnt, 0);
      check("t5_rv0", a0.rvalid, 0);
      tick();
      reset = 1'b0;
      a0.req = 0; a0.we = 0; a0.lock = 0;
      a1.req = 1; a1.we = 0; a1.addr = 32'h40;
      #1;
      check("t5_gnt1", a1.gnt, 1);
      check("t5_mem", rd_a, 32'h1122_3344);
      tick();
      a1.req = 0;
      #1;
      check("t5_rv1", a1.rvalid, 1);
      check("t5_rdata1", a1.rdata, 32'h1122_3344);
      idle_all();
      tick();

      // Round-robin: alternating grants, rvalid lags by one cycle.
      b0.req = 1; b0.addr = 32'h0;
      b1.req = 1; b1.addr = 32'h4;
      for (int k = 0; k < 6; k++) begin
         #1;
         check($sformatf("t3_gnt0_k%0d", k), b0.gnt, (k % 2 == 0) ? 1 : 0);
         check($sformatf("t3_gnt1_k%0d", k), b1.gnt, (k % 2 == 1) ? 1 : 0);
         check($sformatf("t3_rv0_k%0d", k), b0.rvalid, (k % 2 == 1) ? 1 : 0);
         check($sformatf("t3_rv1_k%0d", k), b1.rvalid, (k >= 2 && k % 2 == 0) ? 1 : 0);
         tick();
      end
      idle_all();
      tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
